// File: rtl/demux_1to2_buf_if.sv
// Handshake bundle for demux_1to2_buf: one source stream in, two destination
// streams out. The DUT connects through the slave modport. The environment
// (producer plus both consumers) connects through the master modport.
interface demux_1to2_buf_if #(
   parameter int size = 32
) ();
   logic [size-1:0] data_i;
   logic            select_i;
   logic            valid_i;
   logic            ready_o;
   logic [size-1:0] data0_o;
   logic            valid0_o;
   logic            ready0_i;
   logic [size-1:0] data1_o;
   logic            valid1_o;
   logic            ready1_i;

   modport slave (
      input  data_i, select_i, valid_i, ready0_i, ready1_i,
      output ready_o, data0_o, valid0_o, data1_o, valid1_o
   );

   modport master (
      output data_i, select_i, valid_i, ready0_i, ready1_i,
      input  ready_o, data0_o, valid0_o, data1_o, valid1_o
   );
endinterface

// File: rtl/demux_1to2_buf.sv
// Buffered 1-to-2 demultiplexer. Each source word is steered by select_i into
// a per-destination FIFO of 'depth' entries. Because each side has its own
// buffer, a stalled consumer only blocks words that are headed for its side.
// The interface instance must use the same 'size' as this module.
// Optional macro DEMUX_1TO2_BUF_COUNT_EN adds count0_o/count1_o. These are
// 16-bit wrapping counts of completed output handshakes on each side.
module demux_1to2_buf #(
   parameter int size  = 32,
   parameter int depth = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   demux_1to2_buf_if.slave      bus
`ifdef DEMUX_1TO2_BUF_COUNT_EN
   ,
   output logic [15:0]          count0_o,
   output logic [15:0]          count1_o
`endif
);
   localparam int              AW      = $clog2(depth);
   localparam logic [AW:0]     DEPTH_C = (AW+1)'(depth);
   localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0]   PTR_ONE = AW'(1);

   logic [1:0]      w_full;
   logic [1:0]      w_empty;
   logic [1:0]      w_sel;
   logic [1:0]      w_push;
   logic [1:0]      w_pop;
   logic            w_ready;
   logic [size-1:0] w_head [2];
`ifdef DEMUX_1TO2_BUF_COUNT_EN
   logic [15:0]     r_pop_cnt [2];
`endif

   // A full side refuses the word even if it pops this cycle. This keeps
   // ready_o independent of the consumer ready inputs.
   assign w_ready     = ~w_full[bus.select_i];
   assign bus.ready_o = w_ready;
   assign w_sel       = {bus.select_i, ~bus.select_i};
   assign w_push      = w_sel & {2{bus.valid_i & w_ready}};
   assign w_pop       = ~w_empty & {bus.ready1_i, bus.ready0_i};

   assign bus.valid0_o = ~w_empty[0];
   assign bus.valid1_o = ~w_empty[1];
   assign bus.data0_o  = w_head[0];
   assign bus.data1_o  = w_head[1];

`ifdef DEMUX_1TO2_BUF_COUNT_EN
   assign count0_o = r_pop_cnt[0];
   assign count1_o = r_pop_cnt[1];
`endif

   for (genvar k = 0; k < 2; k++) begin : side_g
      logic [size-1:0] r_mem [depth];
      logic [AW-1:0]   r_wptr;
      logic [AW-1:0]   r_rptr;
      logic [AW:0]     r_count;

      assign w_full[k]  = (r_count == DEPTH_C);
      assign w_empty[k] = (r_count == '0);
      assign w_head[k]  = w_empty[k] ? '0 : r_mem[r_rptr];

      // Pointer and occupancy bookkeeping. Reset wins over push and pop.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push[k]) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop[k])  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push[k], w_pop[k]})
               2'b10:   r_count <= r_count + CNT_ONE;
               2'b01:   r_count <= r_count - CNT_ONE;
               default: r_count <= r_count;
            endcase
         end
      end

      // Storage is not reset. Only the pointers decide which entries are live.
      always_ff @(posedge clk_i) begin
         if (!rst_i && w_push[k]) r_mem[r_wptr] <= bus.data_i;
      end

`ifdef DEMUX_1TO2_BUF_COUNT_EN
      // Completed output handshakes on this side, wrapping at 16 bits.
      always_ff @(posedge clk_i) begin
         if (rst_i)          r_pop_cnt[k] <= '0;
         else if (w_pop[k])  r_pop_cnt[k] <= r_pop_cnt[k] + 16'd1;
      end
`endif
   end
endmodule
